// File: rtl/tm1638_serial_tx_pkg.sv
// Shared type definitions for the TM1638 display driver family.
package tm1638_driver_types;

  // Command-level sequencing states of the display driver.
  typedef enum logic [1:0] {
    DRV_IDLE,
    DRV_MODE,
    DRV_ADDR,
    DRV_DATA
  } state_t;

  // Byte-level serial transmitter states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT_LOW,
    BIT_HIGH,
    HOLD,
    STOP,
    GAP
  } tx_state_t;

endpackage

// File: rtl/tm1638_serial_tx_clk_div.sv
// Half-period timer: loadable down-counter that flags when it reaches zero.
module tm1638_clk_div #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;

  // Reload on request, otherwise count down and rest at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/tm1638_serial_tx.sv
// TM1638 write-only serial transmitter: STB/CLK/DIO framing, LSB first.
module tm1638_serial_tx #(
  parameter int CLK_DIV = 4,
  parameter int STB_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tm_stb,
  output logic       tm_clk,
  output logic       tm_dio,
  output logic       busy
);

  import tm1638_driver_types::*;

  localparam int CNT_W = $clog2(CLK_DIV + STB_GAP + 1);

  tx_state_t        r_state;
  logic [7:0]       r_shift;
  logic             r_last;
  logic [2:0]       r_bit;

  logic             w_accept;
  logic             w_tick;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  assign w_accept   = in_valid && in_ready && ((r_state == IDLE) || (r_state == HOLD));
  // Every timed state change reloads the timer; GAP is the only state entered from STOP.
  assign w_load     = w_accept || (w_tick && (r_state != IDLE) && (r_state != HOLD));
  assign w_load_val = (r_state == STOP) ? CNT_W'(STB_GAP - 1) : CNT_W'(CLK_DIV - 1);

  tm1638_clk_div #(
    .WIDTH(CNT_W)
  ) u_clk_div (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick)
  );

  // Pin outputs are decoded from the current state and so trail the state by one
  // cycle (STB falls one cycle after acceptance); in_ready drops on the accepting
  // edge itself so a byte can never be taken twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_last   <= 1'b0;
      r_bit    <= '0;
      in_ready <= 1'b0;
      tm_stb   <= 1'b1;
      tm_clk   <= 1'b1;
      tm_dio   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      in_ready <= ((r_state == IDLE) || (r_state == HOLD)) && !w_accept;
      case (r_state)
        IDLE: begin
          tm_stb <= 1'b1;
          tm_clk <= 1'b1;
          tm_dio <= 1'b0;
          if (w_accept) begin
            r_shift <= in_data;
            r_last  <= in_last;
            r_bit   <= '0;
            busy    <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          tm_stb <= 1'b0;
          tm_clk <= 1'b1;
          if (w_tick) r_state <= BIT_LOW;
        end
        BIT_LOW: begin
          tm_stb <= 1'b0;
          tm_clk <= 1'b0;
          tm_dio <= r_shift[0];
          if (w_tick) r_state <= BIT_HIGH;
        end
        BIT_HIGH: begin
          tm_stb <= 1'b0;
          tm_clk <= 1'b1;
          if (w_tick) begin
            if (r_bit == 3'd7) begin
              r_state <= r_last ? STOP : HOLD;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              r_state <= BIT_LOW;
            end
          end
        end
        HOLD: begin
          tm_stb <= 1'b0;
          tm_clk <= 1'b1;
          if (w_accept) begin
            r_shift <= in_data;
            r_last  <= in_last;
            r_bit   <= '0;
            r_state <= BIT_LOW;
          end
        end
        STOP: begin
          tm_stb <= 1'b0;
          tm_clk <= 1'b1;
          if (w_tick) r_state <= GAP;
        end
        GAP: begin
          tm_stb <= 1'b1;
          tm_clk <= 1'b1;
          tm_dio <= 1'b0;
          if (w_tick) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_serial_tx.sv
// Self-checking bench for tm1638_serial_tx: scoreboard of sent bytes vs bytes decoded on the pins.
module tb_tm1638_serial_tx;

  localparam int CD = 4;
  localparam int SG = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, tm_stb, tm_clk, tm_dio, busy;

  logic       v2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       l2 = 1'b0;
  logic       rdy2, stb2, clk2o, dio2, busy2;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  // pin monitor state for the default-parameter DUT
  logic       p_stb = 1'b1;
  logic       p_clk = 1'b1;
  logic [7:0] m_sh = 8'h00;
  int m_bits = 0, m_rises = 0, m_low_len = 0, m_high_len = 0;
  int m_last_low = 0, m_last_rises = 0, m_last_high = 0, m_frames = 0, m_viol = 0;

  always #5 clk = ~clk;

  tm1638_serial_tx #(.CLK_DIV(CD), .STB_GAP(SG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio(tm_dio), .busy(busy)
  );

  tm1638_serial_tx #(.CLK_DIV(2), .STB_GAP(1)) dut_fast (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_last(l2),
    .in_ready(rdy2), .tm_stb(stb2), .tm_clk(clk2o), .tm_dio(dio2), .busy(busy2)
  );

  // decode DIO at each CLK rise inside STB-low windows and pop the scoreboard per byte
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      m_bits = 0; p_stb = 1'b1; p_clk = 1'b1; m_high_len = 0;
      exp_q.delete();
    end else begin
      if ((tm_stb !== p_stb) && (tm_clk !== p_clk)) m_viol++;
      if (tm_stb === 1'b0) begin
        if (p_stb) begin
          m_rises = 0; m_low_len = 0; m_bits = 0; m_last_high = m_high_len;
        end
        m_low_len++;
        if (tm_clk === 1'b1 && p_clk === 1'b0) begin
          m_rises++;
          m_sh = {tm_dio, m_sh[7:1]};
          m_bits++;
          if (m_bits == 8) begin
            m_bits = 0;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL byte_unexpected got=%h exp=none", m_sh);
            end else begin
              e = exp_q.pop_front();
              if (m_sh !== e) begin
                failures++;
                $display("FAIL byte_data got=%h exp=%h", m_sh, e);
              end
            end
          end
        end
      end else begin
        if (!p_stb) begin
          m_last_low = m_low_len; m_last_rises = m_rises; m_frames++; m_high_len = 0;
        end
        m_high_len++;
      end
      p_stb = tm_stb;
      p_clk = tm_clk;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input bit keep_valid);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_timeout got=in_ready=%b exp=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(d);
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target);
    int n = 0;
    while (m_frames < target && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (m_frames < target) begin
      failures++;
      $display("FAIL frame_timeout got=%0d exp=%0d", m_frames, target);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_timeout got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tm_stb, tm_clk, tm_dio, in_ready, busy} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=11000", {tm_stb, tm_clk, tm_dio, in_ready, busy});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b exp=0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_first_edge got=%b%b exp=10", in_ready, busy);
    end
  endtask

  task automatic test_single_byte();
    int base = m_frames;
    int n = 0;
    send_byte(8'h8F, 1'b1, 1'b0);
    while (in_ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 1 + 18 * CD + SG) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=%0d", n, 1 + 18 * CD + SG);
    end
    checks++;
    if (m_frames != base + 1) begin
      failures++;
      $display("FAIL single_frames got=%0d exp=%0d", m_frames, base + 1);
    end
    checks++;
    if (m_last_low != 18 * CD) begin
      failures++;
      $display("FAIL single_stb_low got=%0d exp=%0d", m_last_low, 18 * CD);
    end
    checks++;
    if (m_last_rises != 8) begin
      failures++;
      $display("FAIL single_rises got=%0d exp=8", m_last_rises);
    end
    checks++;
    if (exp_q.size() != 0 || m_viol != 0) begin
      failures++;
      $display("FAIL single_leftover got=q%0d/v%0d exp=q0/v0", exp_q.size(), m_viol);
    end
  endtask

  task automatic test_back_to_back();
    int base = m_frames;
    send_byte(8'h40, 1'b0, 1'b1);
    send_byte(8'hC0, 1'b0, 1'b1);
    send_byte(8'h3F, 1'b1, 1'b0);
    wait_frame(base + 1);
    wait_ready();
    checks++;
    if (m_frames != base + 1) begin
      failures++;
      $display("FAIL b2b_windows got=%0d exp=%0d", m_frames - base, 1);
    end
    checks++;
    if (m_last_rises != 24) begin
      failures++;
      $display("FAIL b2b_rises got=%0d exp=24", m_last_rises);
    end
    checks++;
    if (exp_q.size() != 0 || m_viol != 0) begin
      failures++;
      $display("FAIL b2b_leftover got=q%0d/v%0d exp=q0/v0", exp_q.size(), m_viol);
    end
  endtask

  task automatic test_gap();
    int base = m_frames;
    int n = 0;
    send_byte(8'h81, 1'b1, 1'b1);
    in_data = 8'h7E; in_last = 1'b1;
    exp_q.push_back(8'h7E);
    while (tm_stb !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (tm_stb !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    for (int i = 0; i < SG; i++) begin
      checks++;
      if (tm_stb !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL gap_cycle%0d got=stb%b/rdy%b exp=stb1/rdy0", i, tm_stb, in_ready);
      end
      if (i < SG - 1) @(negedge clk);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_frame(base + 2);
    wait_ready();
    checks++;
    if (m_last_high < SG) begin
      failures++;
      $display("FAIL gap_stb_high got=%0d exp>=%0d", m_last_high, SG);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL gap_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_byte();
    int base;
    int n = 0;
    send_byte(8'hA5, 1'b1, 1'b0);
    while (!(tm_stb === 1'b0 && m_rises == 3) && n < 500) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tm_stb, tm_clk, tm_dio, in_ready, busy} !== 5'b11000) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=11000", {tm_stb, tm_clk, tm_dio, in_ready, busy});
    end
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    base = m_frames;
    send_byte(8'h5A, 1'b1, 1'b0);
    wait_frame(base + 1);
    wait_ready();
    checks++;
    if (m_last_rises != 8 || m_last_low != 18 * CD) begin
      failures++;
      $display("FAIL midreset_frame got=r%0d/l%0d exp=r8/l%0d", m_last_rises, m_last_low, 18 * CD);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_data_hold();
    int base = m_frames;
    send_byte(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_data = 8'($urandom);
      in_last = 1'b0;
    end
    wait_frame(base + 1);
    wait_ready();
    checks++;
    if (m_frames != base + 1 || m_last_rises != 8) begin
      failures++;
      $display("FAIL hold_frame got=f%0d/r%0d exp=f1/r8", m_frames - base, m_last_rises);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL hold_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_fast_div();
    int n = 0;
    int low_len = 0, lruns = 0, run = 0;
    bit started = 0, seen_low = 0;
    logic pc = 1'b1;
    logic [7:0] sh = 8'h00;
    logic [7:0] e;
    @(negedge clk);
    v2 = 1'b1; d2 = 8'h96; l2 = 1'b1;
    while (rdy2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    exp2_q.push_back(8'h96);
    @(posedge clk); #1;
    v2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stb2 === 1'b0) begin
        started = 1;
        low_len++;
        if (clk2o !== pc) begin
          if (pc === 1'b0) begin
            checks++;
            if (run != 2) begin
              failures++;
              $display("FAIL fast_low_half got=%0d exp=2", run);
            end
            lruns++;
            sh = {dio2, sh[7:1]};
          end else if (seen_low) begin
            checks++;
            if (run != 2) begin
              failures++;
              $display("FAIL fast_high_half got=%0d exp=2", run);
            end
          end
          if (clk2o === 1'b0) seen_low = 1;
          run = 1;
          pc = clk2o;
        end else begin
          run++;
        end
      end else if (started) begin
        break;
      end
    end
    checks++;
    if (!started || low_len != 36) begin
      failures++;
      $display("FAIL fast_stb_low got=%0d exp=36", low_len);
    end
    checks++;
    if (lruns != 8) begin
      failures++;
      $display("FAIL fast_rises got=%0d exp=8", lruns);
    end
    checks++;
    if (exp2_q.size() == 0) begin
      failures++;
      $display("FAIL fast_byte got=%h exp=none", sh);
    end else begin
      e = exp2_q.pop_front();
      if (sh !== e) begin
        failures++;
        $display("FAIL fast_byte got=%h exp=%h", sh, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_gap();
    test_reset_mid_byte();
    test_data_hold();
    test_fast_div();
    checks++;
    if (m_viol != 0) begin
      failures++;
      $display("FAIL clk_stb_same_cycle got=%0d exp=0", m_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_serial_tx.md
TM1638_SERIAL_TX -- requirements
Module: tm1638_serial_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning system cycles per TM1638 CLK half-period (legal minimum 2).
REQ-002 The block SHALL have parameter STB_GAP, default 4, meaning minimum system cycles STB stays high between frames (legal minimum 1).
REQ-003 The block SHALL have port clk  input  1  the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  the upstream driver offers a command/data byte.
REQ-006 The block SHALL have port in_data  input  8  the byte to shift out.
REQ-007 The block SHALL have port in_last  input  1  the byte ends the frame, so STB rises after it.
REQ-008 The block SHALL have port in_ready  output  1  the byte is accepted on a cycle where in_valid and in_ready are both high.
REQ-009 The block SHALL have port tm_stb  output  1  TM1638 STB, active low.
REQ-010 The block SHALL have port tm_clk  output  1  TM1638 CLK, idles high.
REQ-011 The block SHALL have port tm_dio  output  1  TM1638 DIO, write-only and always driven.
REQ-012 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL use the FSM states IDLE, START, BIT_LOW, BIT_HIGH, HOLD, STOP and GAP, with all outputs registered.
REQ-014 In IDLE the block SHALL hold tm_stb=1, tm_clk=1, tm_dio=0 and in_ready=1, and SHALL go to START on acceptance.
REQ-015 On acceptance the block SHALL latch in_data into a shift register and in_last into a flag, and SHALL ignore in_data/in_last changes afterwards.
REQ-016 In START the block SHALL drive tm_stb=0 and tm_clk=1 for CLK_DIV cycles, with tm_stb falling 1 cycle after the acceptance edge, then go to BIT_LOW.
REQ-017 In BIT_LOW the block SHALL drive tm_clk=0 and tm_dio=current bit for CLK_DIV cycles, starting with bit 0 (LSB first).
REQ-018 In BIT_HIGH the block SHALL drive tm_clk=1 with tm_dio unchanged for CLK_DIV cycles, which gives data setup of CLK_DIV cycles before the rising edge.
REQ-019 After BIT_HIGH of bits 0..6 the block SHALL shift right and return to BIT_LOW.
REQ-020 After BIT_HIGH of bit 7 the block SHALL go to STOP if the last flag is set, otherwise to HOLD.
REQ-021 In HOLD the block SHALL hold tm_stb=0, tm_clk=1 and in_ready=1, wait without timeout, and go straight to BIT_LOW on acceptance.
REQ-022 In STOP the block SHALL hold tm_stb=0 and tm_clk=1 for CLK_DIV cycles, then raise tm_stb and go to GAP.
REQ-023 In GAP the block SHALL hold tm_stb=1 and in_ready=0 for STB_GAP cycles, then go to IDLE.
REQ-024 in_ready SHALL be high only in IDLE and HOLD, and acceptance in any other state SHALL be impossible.
REQ-025 For a single-byte frame, tm_stb SHALL stay low for exactly 18*CLK_DIV cycles, and acceptance to next in_ready SHALL take 1+18*CLK_DIV+STB_GAP cycles.
REQ-026 Each byte SHALL produce exactly 8 tm_clk rising edges, and tm_clk SHALL never change in the same cycle as tm_stb.
REQ-027 The half-period counter SHALL be $clog2(CLK_DIV+STB_GAP+1) bits wide, count down to 0, and reload on every state change; the bit counter SHALL be 3 bits wide.

Reset
REQ-028 Asserting rst at any time, including mid-byte, SHALL force IDLE, tm_stb=1, tm_clk=1, tm_dio=0, in_ready=0, busy=0 and clear all counters and shift state.
REQ-029 in_ready SHALL first rise on the first clk edge after rst deasserts, and the partial frame aborted by reset SHALL NOT be resumed.

Structure
REQ-030 The state enum tx_state_t SHALL be added to the shared package tm1638_driver_types, next to state_t.
REQ-031 The half-period tick SHALL be a sub-module tm1638_clk_div (down-counter plus reload, tick output), instantiated once.

Verification
REQ-032 Test 1: single byte 0x8F with in_last=1, CLK_DIV=4 -> tm_stb low 72 cycles, 8 tm_clk rises, DIO at the rises = 1,1,1,1,0,0,0,1.
REQ-033 Test 2: frame 0x40 (last=0), 0xC0 (last=0), 0x3F (last=1) offered back-to-back -> one STB-low window, 24 clock rises, tm_stb held low in HOLD, bytes decoded in order.
REQ-034 Test 3: in_valid held high continuously with last=1 -> tm_stb stays high for at least STB_GAP=4 cycles between frames, and in_ready stays 0 during GAP.
REQ-035 Test 4: rst pulsed after the 3rd clock rise of 0xA5 -> outputs go to reset values asynchronously, a later byte 0x5A transmits cleanly, and there is no residual bit.
REQ-036 Test 5: in_data changes after acceptance, mid-byte -> transmitted bits match the latched value.
REQ-037 Test 6: CLK_DIV=2, STB_GAP=1 -> each tm_clk half-period is exactly 2 cycles and STB low lasts 36 cycles.
